// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_if
// Description : Fetch-stage bus bundle: instruction ROM port, redirect input,
//               decode output slot and debug counter.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if #(
    parameter int A_WIDTH = 32,
    parameter int D_WIDTH = 32
);
    logic [A_WIDTH-1:0] imem_a;
    logic [D_WIDTH-1:0] imem_rd;
    logic               redirect_valid;
    logic [A_WIDTH-1:0] redirect_pc;
    logic               out_valid;
    logic               out_ready;
    logic [D_WIDTH-1:0] out_instr;
    logic [A_WIDTH-1:0] out_pc;
    logic [A_WIDTH-1:0] out_pc_plus4;
    logic               misalign_err;
    logic [31:0]        retired_cnt;

    modport master (
        output imem_a, out_valid, out_instr, out_pc, out_pc_plus4,
               misalign_err, retired_cnt,
        input  imem_rd, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_a, out_valid, out_instr, out_pc, out_pc_plus4,
               misalign_err, retired_cnt,
        output imem_rd, redirect_valid, redirect_pc, out_ready
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : PC owner and single-entry valid/ready instruction slot with
//               redirect flush and retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int                 A_WIDTH  = 32,
    parameter int                 D_WIDTH  = 32,
    parameter logic [A_WIDTH-1:0] RESET_PC = {A_WIDTH{1'b0}}
) (
    input  wire logic          clk,
    input  wire logic          rst,
    instr_fetch_if.master      bus
);

    localparam logic [A_WIDTH-1:0] c_PC_STEP = A_WIDTH'(4);

    logic [A_WIDTH-1:0] r_pc;
    logic               r_out_valid;
    logic [D_WIDTH-1:0] r_out_instr;
    logic [A_WIDTH-1:0] r_out_pc;
    logic [A_WIDTH-1:0] r_out_pc_plus4;
    logic               r_misalign_err;
    logic [31:0]        r_retired_cnt;

    logic               w_load;
    logic               w_xfer;
    logic [A_WIDTH-1:0] w_pc_next_seq;
    logic [A_WIDTH-1:0] w_redirect_aligned;

    assign w_load             = !r_out_valid || bus.out_ready;
    assign w_xfer             = r_out_valid && bus.out_ready;
    assign w_pc_next_seq      = r_pc + c_PC_STEP;
    assign w_redirect_aligned = {bus.redirect_pc[A_WIDTH-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc           <= RESET_PC;
            r_out_valid    <= 1'b0;
            r_out_instr    <= '0;
            r_out_pc       <= '0;
            r_out_pc_plus4 <= '0;
            r_misalign_err <= 1'b0;
            r_retired_cnt  <= '0;
        end else begin
            r_misalign_err <= 1'b0;
            // A handshake completes even when a redirect flushes the slot.
            if (w_xfer) begin
                r_retired_cnt <= r_retired_cnt + 32'd1;
            end
            if (bus.redirect_valid) begin
                r_pc           <= w_redirect_aligned;
                r_out_valid    <= 1'b0;
                r_misalign_err <= (bus.redirect_pc[1:0] != 2'b00);
            end else if (w_load) begin
                r_out_instr    <= bus.imem_rd;
                r_out_pc       <= r_pc;
                r_out_pc_plus4 <= w_pc_next_seq;
                r_out_valid    <= 1'b1;
                r_pc           <= w_pc_next_seq;
            end
        end
    end

    assign bus.imem_a       = r_pc;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_instr    = r_out_instr;
    assign bus.out_pc       = r_out_pc;
    assign bus.out_pc_plus4 = r_out_pc_plus4;
    assign bus.misalign_err = r_misalign_err;
    assign bus.retired_cnt  = r_retired_cnt;

endmodule
`default_nettype wire
